// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ requesters.
// Optional macro UART_TX_ARB_CHAN_ID_EN prefixes each payload with a channel-id header frame.
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int DATA_W        = 8,
  parameter int START_TIMEOUT = 1023,
  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W = $clog2(START_TIMEOUT + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          ack,
  output logic                        err,
  output logic [ID_W-1:0]             grant_id,
  output logic                        active,
  output logic                        tx_enable,
  output logic [DATA_W-1:0]           tx_data,
  input  logic                        tx_busy
);

  typedef enum logic [1:0] {IDLE, START, WAIT_DONE, ACK} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [ID_W-1:0]     grant_id_q, grant_id_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic                tx_enable_q, tx_enable_d;
  logic                active_q, active_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic                err_q, err_d;

  logic                found;
  logic [ID_W-1:0]     winner;
  logic [ID_W-1:0]     cand;
  logic [NUM_REQ-1:0]  ack_onehot;

`ifdef UART_TX_ARB_CHAN_ID_EN
  logic                hdr_q, hdr_d;
  logic [DATA_W-1:0]   payload_q, payload_d;
`endif

  // First set request at or above the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign ack_onehot = NUM_REQ'(1) << grant_id_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    grant_id_d  = grant_id_q;
    tx_data_d   = tx_data_q;
    tx_enable_d = tx_enable_q;
    active_d    = active_q;
    ack_d       = '0;
    err_d       = 1'b0;
`ifdef UART_TX_ARB_CHAN_ID_EN
    hdr_d       = hdr_q;
    payload_d   = payload_q;
`endif
    case (state_q)
      IDLE: begin
        if (found && !tx_busy) begin
          grant_id_d  = winner;
          tx_enable_d = 1'b1;
          active_d    = 1'b1;
          cnt_d       = '0;
          state_d     = START;
`ifdef UART_TX_ARB_CHAN_ID_EN
          payload_d   = req_data[winner*DATA_W +: DATA_W];
          tx_data_d   = {1'b1, (DATA_W-1)'(winner)};
          hdr_d       = 1'b1;
`else
          tx_data_d   = req_data[winner*DATA_W +: DATA_W];
`endif
        end
      end
      START: begin
        if (tx_busy) begin
          tx_enable_d = 1'b0;
          state_d     = WAIT_DONE;
        end else if (cnt_q == CNT_W'(START_TIMEOUT)) begin
          // Transmitter never started: abandon any remaining frame and ack with err.
          tx_enable_d = 1'b0;
          ack_d       = ack_onehot;
          err_d       = 1'b1;
          state_d     = ACK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
`ifdef UART_TX_ARB_CHAN_ID_EN
          if (hdr_q) begin
            hdr_d       = 1'b0;
            tx_data_d   = payload_q;
            tx_enable_d = 1'b1;
            cnt_d       = '0;
            state_d     = START;
          end else begin
            ack_d   = ack_onehot;
            state_d = ACK;
          end
`else
          ack_d   = ack_onehot;
          state_d = ACK;
`endif
        end
      end
      ACK: begin
        active_d = 1'b0;
        ptr_d    = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ptr_q       <= '0;
      grant_id_q  <= '0;
      tx_data_q   <= '0;
      tx_enable_q <= 1'b0;
      active_q    <= 1'b0;
      ack_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      grant_id_q  <= grant_id_d;
      tx_data_q   <= tx_data_d;
      tx_enable_q <= tx_enable_d;
      active_q    <= active_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
    end
  end

`ifdef UART_TX_ARB_CHAN_ID_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hdr_q     <= 1'b0;
      payload_q <= '0;
    end else begin
      hdr_q     <= hdr_d;
      payload_q <= payload_d;
    end
  end
`endif

  assign ack       = ack_q;
  assign err       = err_q;
  assign grant_id  = grant_id_q;
  assign active    = active_q;
  assign tx_enable = tx_enable_q;
  assign tx_data   = tx_data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: single transfer, fairness, timeout, busy-blocked start, async reset.
module tb_uart_tx_arbiter;
  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
  localparam int TMO     = 1023;

  logic                      clk;
  logic                      rst;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        ack;
  logic                      err;
  logic [1:0]                grant_id;
  logic                      active;
  logic                      tx_enable;
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_busy;

  int vectors = 0;
  int miscompares = 0;
  int n;
  int n_ack;
  int exp_id;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .START_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack), .err(err),
    .grant_id(grant_id), .active(active), .tx_enable(tx_enable), .tx_data(tx_data),
    .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; req = '0; req_data = '0; tx_busy = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_en",   32'(tx_enable), 0);
    chk("rst_act",  32'(active), 0);
    chk("rst_ack",  32'(ack), 0);
    chk("rst_err",  32'(err), 0);
    chk("rst_gid",  32'(grant_id), 0);
    chk("rst_data", 32'(tx_data), 0);

    // single request, busy rises on the third tx_enable cycle
    req_data = {8'h44, 8'h5A, 8'h22, 8'h11};
    req = 4'b0100; rst = 1'b0;
    @(negedge clk);
    chk("t1_en0",  32'(tx_enable), 1);
    chk("t1_gid",  32'(grant_id), 2);
    chk("t1_data", 32'(tx_data), 32'h5A);
    chk("t1_act",  32'(active), 1);
    @(negedge clk); chk("t1_en1", 32'(tx_enable), 1);
    @(negedge clk); chk("t1_en2", 32'(tx_enable), 1);
    tx_busy = 1'b1;
    @(negedge clk);
    chk("t1_en_off", 32'(tx_enable), 0);
    chk("t1_act_busy", 32'(active), 1);
    n_ack = 0;
    repeat (19) begin
      @(negedge clk);
      if (ack != 0) n_ack++;
    end
    chk("t1_no_early_ack", 32'(n_ack), 0);
    tx_busy = 1'b0;
    @(negedge clk);
    chk("t1_ack", 32'(ack), 32'b0100);
    chk("t1_err", 32'(err), 0);
    chk("t1_act_ack", 32'(active), 1);
    req = '0;
    @(negedge clk);
    chk("t1_ack_pulse", 32'(ack), 0);
    chk("t1_act_end", 32'(active), 0);

    // fairness from a fresh pointer
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; req = 4'b1111;
    for (int t = 0; t < 8; t++) begin
      exp_id = t % 4;
      n = 0;
      while (!tx_enable && n < 20) begin @(negedge clk); n++; end
      chk("t2_grant_seen", 32'(tx_enable), 1);
      chk("t2_gid", 32'(grant_id), 32'(exp_id));
      chk("t2_data", 32'(tx_data), 32'(req_data[exp_id*8 +: 8]));
      tx_busy = 1'b1;
      repeat (3) @(negedge clk);
      tx_busy = 1'b0;
      n = 0;
      while (ack == 0 && n < 20) begin @(negedge clk); n++; end
      chk("t2_ack", 32'(ack), 32'(1 << exp_id));
      @(negedge clk);
      chk("t2_ack_pulse", 32'(ack), 0);
    end

    // start timeout with busy tied low
    req = 4'b0001;
    n = 0;
    while (!tx_enable && n < 20) begin @(negedge clk); n++; end
    chk("t3_grant_seen", 32'(tx_enable), 1);
    n = 0;
    while (tx_enable && n < 2000) begin n++; @(negedge clk); end
    chk("t3_en_cycles", 32'(n), TMO + 1);
    chk("t3_ack", 32'(ack), 32'b0001);
    chk("t3_err", 32'(err), 1);
    req = 4'b1011;
    @(negedge clk);
    chk("t3_err_pulse", 32'(err), 0);
    @(negedge clk);
    chk("t3_next_en",  32'(tx_enable), 1);
    chk("t3_next_gid", 32'(grant_id), 1);
    tx_busy = 1'b1;
    repeat (2) @(negedge clk);
    tx_busy = 1'b0; req = '0;
    n = 0;
    while (ack == 0 && n < 20) begin @(negedge clk); n++; end
    chk("t3_next_ack", 32'(ack), 32'b0010);
    chk("t3_next_err", 32'(err), 0);
    @(negedge clk);

    // busy high at reset release blocks the grant; request dropped after grant
    rst = 1'b1; tx_busy = 1'b1; req = 4'b0010;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("t4_blocked_en",  32'(tx_enable), 0);
    chk("t4_blocked_act", 32'(active), 0);
    tx_busy = 1'b0;
    @(negedge clk);
    chk("t4_en",  32'(tx_enable), 1);
    chk("t4_gid", 32'(grant_id), 1);
    req = '0; tx_busy = 1'b1;
    repeat (2) @(negedge clk);
    tx_busy = 1'b0;
    n = 0;
    while (ack == 0 && n < 20) begin @(negedge clk); n++; end
    chk("t4_ack", 32'(ack), 32'b0010);
    @(negedge clk);

    // async reset while waiting for frame completion
    req = 4'b0100;
    n = 0;
    while (!tx_enable && n < 20) begin @(negedge clk); n++; end
    chk("t5_gid", 32'(grant_id), 2);
    tx_busy = 1'b1;
    @(negedge clk);
    chk("t5_wait_en", 32'(tx_enable), 0);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_act",  32'(active), 0);
    chk("t5_rst_en",   32'(tx_enable), 0);
    chk("t5_rst_gid",  32'(grant_id), 0);
    chk("t5_rst_data", 32'(tx_data), 0);
    chk("t5_rst_ack",  32'(ack), 0);
    @(negedge clk);
    rst = 1'b0; tx_busy = 1'b0; req = 4'b1000;
    @(negedge clk);
    chk("t5_en",  32'(tx_enable), 1);
    chk("t5_gid3", 32'(grant_id), 3);
    chk("t5_no_ack", 32'(ack), 0);
    tx_busy = 1'b1;
    repeat (2) @(negedge clk);
    tx_busy = 1'b0; req = '0;
    n = 0;
    while (ack == 0 && n < 20) begin @(negedge clk); n++; end
    chk("t5_ack", 32'(ack), 32'b1000);
    @(negedge clk);

`ifdef UART_TX_ARB_CHAN_ID_EN
    // header frame then payload frame, single ack
    req_data[15:8] = 8'hC3;
    req = 4'b0010;
    n = 0;
    while (!tx_enable && n < 20) begin @(negedge clk); n++; end
    chk("t6_hdr", 32'(tx_data), 32'h81);
    tx_busy = 1'b1;
    @(negedge clk);
    chk("t6_hdr_off", 32'(tx_enable), 0);
    @(negedge clk);
    tx_busy = 1'b0;
    @(negedge clk);
    chk("t6_pay_en",  32'(tx_enable), 1);
    chk("t6_pay",     32'(tx_data), 32'hC3);
    chk("t6_mid_ack", 32'(ack), 0);
    tx_busy = 1'b1;
    repeat (2) @(negedge clk);
    tx_busy = 1'b0; req = '0;
    n = 0;
    while (ack == 0 && n < 20) begin @(negedge clk); n++; end
    chk("t6_ack", 32'(ack), 32'b0010);
    @(negedge clk);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter and sequencer that shares one UART transmitter among NUM_REQ requesters. It latches the winning requester's byte and drives the transmitter's tx_enable/data inputs. It then tracks the transmitter's busy flag through a full frame and acknowledges the requester. It sits in the system clock domain between client logic and the transmitter FSM/shift register.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, payload width per requester
START_TIMEOUT, 1023, max clk cycles to wait for tx_busy rise after tx_enable (>=2)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
req  in  NUM_REQ  per-requester request level; held until its ack
req_data  in  NUM_REQ*DATA_W  requester i data at bits [i*DATA_W +: DATA_W]
ack  out  NUM_REQ  one-cycle pulse on the serviced requester's bit
err  out  1  one-cycle pulse, coincident with ack, when a transfer timed out
grant_id  out  max(1,clog2(NUM_REQ))  index of current or last granted requester
active  out  1  high from grant until ack cycle inclusive
tx_enable  out  1  start request to transmitter
tx_data  out  DATA_W  byte presented to transmitter, stable while active
tx_busy  in  1  transmitter busy, already synchronized to clk upstream

Behaviour:
- Reset (async, rst=1): state IDLE; ack=0, err=0, grant_id=0, active=0, tx_enable=0, tx_data=0; RR pointer=0; timeout counter=0. Reset mid-frame abandons the transfer with no ack.
- All outputs registered.
- States: IDLE, START, WAIT_DONE, ACK.
- IDLE: grant only when |req and tx_busy=0. Winner = first set req bit searching from pointer upward, wrapping modulo NUM_REQ. On that edge: latch tx_data<=req_data slice, grant_id<=winner, tx_enable<=1, active<=1, counter<=0; go START.
- Latency: req sampled high at edge n (IDLE, busy low) -> tx_enable high after edge n.
- START: tx_enable held high. tx_busy=1 -> tx_enable<=0, go WAIT_DONE. Otherwise counter++.
- START timeout: counter reaches START_TIMEOUT with tx_busy still 0 -> tx_enable<=0, set err flag, go ACK.
- WAIT_DONE: wait for tx_busy=0, then go ACK. No timeout here, since frame length is owned by the transmitter.
- ACK (one cycle): ack[grant_id]=1; err=1 if flagged; active=0 after this cycle; pointer<=grant_id+1 (wrap to 0 past NUM_REQ-1); return IDLE.
- Earliest next grant is the cycle after ACK, so ack and tx_enable are never high together.
- req deasserted after grant: the transfer still completes and is acked; the latched data is used.
- req_data changes after grant: ignored.
- Simultaneous requests: strict round-robin. A requester holding req continuously is served at least once every NUM_REQ transfers.
- tx_busy high in IDLE, e.g. after rst released mid-frame: no grant until it falls.
- Ignored inputs:
  - tx_busy glitch low for one cycle in START: no effect, only the rise is acted on.
  - tx_busy low in WAIT_DONE: completion.

Optional Feature:
Macro UART_TX_ARB_CHAN_ID_EN.
- Defined: each grant sends two frames. First the header byte, tx_data = {1'b1, grant_id zero-extended to DATA_W-1}. Then the payload. Sequence is START/WAIT_DONE for the header, then START/WAIT_DONE for the payload, then ACK. The timeout applies to each START independently and aborts the remaining frame; err pulses with ack.
- Not defined: single payload frame per grant exactly as above. No header logic is synthesized.

Test Plan:
1. Single request: req=4'b0100, data2=8'h5A, tx_busy model rises 3 cycles after tx_enable and stays high 20 cycles -> tx_enable high for 3 cycles, tx_data=8'h5A, ack=4'b0100 one cycle, grant_id=2, err=0.
2. Fairness: req=4'b1111 held for 8 transfers -> grant order 0,1,2,3,0,1,2,3; each ack a single pulse.
3. Timeout: req=4'b0001, tx_busy tied 0 -> tx_enable high exactly START_TIMEOUT+1 cycles, then ack=4'b0001 with err=1; next grant starts from pointer 1.
4. Busy-blocked start plus dropped request: tx_busy=1 at reset release with req=4'b0010 -> no tx_enable until tx_busy falls. Then grant 1; drop req after grant -> ack still pulses.
5. Async reset in WAIT_DONE: assert rst -> all outputs 0 immediately, no ack; after release with tx_busy=0 and req=4'b1000 -> grant_id=3.
6. With UART_TX_ARB_CHAN_ID_EN: req=4'b0010, data=8'hC3 -> tx_data 8'h81 then 8'hC3 across two busy cycles, single ack.
